// File: rtl/ro_delay_monitor_pkg.sv
// ro_delay_monitor_pkg
//   Shared definitions for the ring-oscillator delay monitor:
//   FSM state encoding (2 bits) and default widths.
package ro_delay_monitor_pkg;

  localparam int WIN_W_DEF = 16;  // gate-window length width (clk cycles)
  localparam int CNT_W_DEF = 20;  // edge counter / result width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : ro_delay_monitor_pkg

// File: rtl/ro_edge_sync.sv
// ro_edge_sync
//   Brings the asynchronous ring-oscillator output into the clk domain through
//   a three-flop chain and emits a one-cycle pulse per rising edge.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (clears the chain)
//   ro_in    in   ring-oscillator output, asynchronous to clk
//   edge_o   out  one-cycle pulse for each rising edge of ro_in
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic edge_o
);

  // sync_q[0] = s1 (metastability catcher), sync_q[1] = s2, sync_q[2] = s3
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], ro_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  // s2 high while s3 still low marks the first clk cycle after a rising edge
  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule : ro_edge_sync

// File: rtl/ro_delay_monitor.sv
// ro_delay_monitor
//   Counts rising edges of a free-running ring oscillator over a programmable
//   window of clk cycles. The resulting count tracks cell propagation delay.
// Ports
//   clk       in   system clock, all logic on rising edge
//   rst_n     in   asynchronous active-low reset
//   ro_in     in   ring-oscillator output (asynchronous, freq < clk/2)
//   start     in   measurement request, honoured only in IDLE
//   window    in   gate length in clk cycles, sampled with start
//   busy      out  high in ARM, COUNT and DONE
//   done      out  one-cycle pulse, count/overflow valid in that cycle
//   count     out  rising edges seen in the last window, held until next done
//   overflow  out  last result saturated at all-ones
module ro_delay_monitor
  import ro_delay_monitor_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               ro_edge;
  logic [CNT_W-1:0]   acc_step;
  logic               ovf_step;
  logic               last_count;

  ro_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_in  (ro_in),
    .edge_o (ro_edge)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // remaining is loaded with window >= 1 and leaves COUNT at 1, so it never wraps
  assign last_count = (remaining_q == WIN_W'(1));

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (window != '0) ? ST_ARM : ST_DONE;
        end
      end
      ST_ARM:   state_d = ST_COUNT;
      ST_COUNT: if (last_count) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign count    = count_q;
  assign overflow = overflow_q;

  // ------------------------------------------------------------- accumulator
  // Saturating step: an edge arriving while already all-ones flags overflow
  // and leaves the accumulator pinned.
  always_comb begin
    acc_step = acc_q;
    ovf_step = ovf_acc_q;
    if (ro_edge) begin
      if (&acc_q) begin
        ovf_step = 1'b1;
      end else begin
        acc_step = acc_q + CNT_W'(1);
      end
    end
  end

  // Result registers load on the edge into DONE so that count/overflow are
  // already valid while done is high; the edge on the last COUNT cycle is
  // folded in through acc_step.
  always_comb begin
    remaining_d = remaining_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = window;
          acc_d       = '0;
          ovf_acc_d   = 1'b0;
          if (window == '0) begin
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
      end
      ST_ARM: begin
        // edge pulse here may belong to the time before start; drop it
      end
      ST_COUNT: begin
        acc_d       = acc_step;
        ovf_acc_d   = ovf_step;
        remaining_d = remaining_q - WIN_W'(1);
        if (last_count) begin
          count_d    = acc_step;
          overflow_d = ovf_step;
        end
      end
      ST_DONE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule : ro_delay_monitor

// File: tb/tb_ro_delay_monitor.sv
// tb_ro_delay_monitor
//   Drives two monitor instances (CNT_W=20 and CNT_W=4) from one oscillator
//   model. Each accepted start pushes an expected result (count range,
//   overflow, done cycle, busy length) into a queue; a negedge monitor pops
//   and compares whenever done is seen.
module tb_ro_delay_monitor;

  localparam int WIN_W = 16;
  localparam int CNT_W = 20;
  localparam int CNT4_W = 4;

  typedef struct {
    int lo;
    int hi;
    int ovf;
    int done_cyc;
    int busy_len;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ro_in;
  logic             start = 1'b0;
  logic [WIN_W-1:0] window = '0;
  logic             busy, done, overflow;
  logic [CNT_W-1:0] count;
  logic             start4 = 1'b0;
  logic [WIN_W-1:0] window4 = '0;
  logic             busy4, done4, overflow4;
  logic [CNT4_W-1:0] count4;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ro_mode = 0;  // 0: stuck low, 1: stuck high, 2: clk/4 square wave
  logic ro_phase = 1'b0;
  exp_t q20[$];
  exp_t q4[$];
  int   busy_cnt = 0;
  int   busy4_cnt = 0;

  ro_delay_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start), .window(window),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ro_delay_monitor #(.WIN_W(WIN_W), .CNT_W(CNT4_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start4), .window(window4),
    .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 40 ns period oscillator, phase offset so its edges never align with clk
  initial begin
    #3;
    forever begin
      #20;
      ro_phase = ~ro_phase;
    end
  end
  assign ro_in = (ro_mode == 2) ? ro_phase : (ro_mode == 1);

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected result from the oscillator model: ideal = window*10ns/40ns
  function automatic exp_t model(input int w, input int cnt_bits, input int t0);
    exp_t e;
    int   ideal;
    int   maxv;
    maxv = (1 << cnt_bits) - 1;
    ideal = (ro_mode == 2) ? (w / 4) : 0;
    if (ideal == 0) begin
      e.lo = 0;
      e.hi = 0;
    end else begin
      e.lo = ideal - 1;
      e.hi = ideal + 1;
    end
    e.ovf = 0;
    if (e.lo > maxv) begin
      e.lo  = maxv;
      e.hi  = maxv;
      e.ovf = 1;
    end
    e.done_cyc = (w == 0) ? t0 + 1 : t0 + w + 2;
    e.busy_len = (w == 0) ? 1 : w + 2;
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      busy4_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy4) busy4_cnt++;
      if (done) begin
        if (q20.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q20.pop_front();
          check("count_in_range", (int'(count) >= e.lo && int'(count) <= e.hi), 1);
          check("overflow", overflow, e.ovf);
          check("done_cycle", cyc, e.done_cyc);
          check("busy_len", busy_cnt, e.busy_len);
          $display("txn cnt20: count=%0d ovf=%0d done@%0d busy_len=%0d", count, overflow, cyc, busy_cnt);
        end
        busy_cnt = 0;
      end
      if (done4) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 1, 0);
        end else begin
          e = q4.pop_front();
          check("count4_in_range", (int'(count4) >= e.lo && int'(count4) <= e.hi), 1);
          check("overflow4", overflow4, e.ovf);
          check("done4_cycle", cyc, e.done_cyc);
          check("busy4_len", busy4_cnt, e.busy_len);
          $display("txn cnt4: count=%0d ovf=%0d done@%0d busy_len=%0d", count4, overflow4, cyc, busy4_cnt);
        end
        busy4_cnt = 0;
      end
    end
  end

  // Issue one start pulse; returns the cycle in which start was presented
  task automatic kick(input bit use4, input int w, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    if (use4) begin
      start4  = 1'b1;
      window4 = WIN_W'(w);
      q4.push_back(model(w, CNT4_W, t0));
    end else begin
      start  = 1'b1;
      window = WIN_W'(w);
      q20.push_back(model(w, CNT_W, t0));
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (q20.size() == 0 && q4.size() == 0 && !busy && !busy4) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_timeout", ok, 1);
  endtask

  initial begin
    int t0;
    int dc;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    #1 rst_n = 1'b1;

    // 1: clk/4 oscillator, window 100
    ro_mode = 2;
    repeat (5) @(posedge clk);
    kick(0, 100, t0);
    wait_idle(200);

    // 2: narrow counter saturates, then a short window fits
    kick(1, 100, t0);
    wait_idle(200);
    kick(1, 20, t0);
    wait_idle(100);

    // 3: zero window completes immediately
    kick(0, 0, t0);
    wait_idle(20);

    // 5: stuck low, then stuck high
    ro_mode = 0;
    repeat (5) @(posedge clk);
    kick(0, 50, t0);
    wait_idle(100);
    ro_mode = 1;
    repeat (5) @(posedge clk);
    kick(0, 50, t0);
    wait_idle(100);

    // 4: start re-pulsed during COUNT and on the done cycle
    ro_mode = 2;
    repeat (5) @(posedge clk);
    kick(0, 40, t0);
    dc = t0 + 42;
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    window = WIN_W'(7);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100 && cyc != dc; i++) begin
      @(posedge clk);
      #1;
    end
    check("reached_done_cycle", cyc, dc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(50);
    kick(0, 60, t0);
    wait_idle(100);

    // 6: asynchronous reset in the middle of COUNT
    kick(0, 100, t0);
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_count", count, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_count4", count4, 0);
    q20.delete();
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    kick(0, 100, t0);
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ro_delay_monitor
